// File: rtl/ray_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// ray_bounce_ctrl
// Per-pixel path sequencer for one tracing lane. Accepts a camera ray, issues
// trace requests to the intersector, forwards hits to the reflector, collects
// reflected rays for up to MAX_BOUNCES bounces and emits the pixel color.
//
// Number formats:
//   fp24       : 24-bit float {sign[23], exp[22:16] (bias 63), mant[15:0]}
//   fp24_vec3  : 72 bits {x[71:48], y[47:24], z[23:0]}
//   fp24_color : 72 bits {r[71:48], g[47:24], b[23:0]}
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start / start_ready        camera ray handshake (accepted only in IDLE)
//   cam_origin, cam_dir,
//   pixel_idx_in               camera ray, sampled on accept
//   trace_valid, trace_origin,
//   trace_dir                  intersector request (ray held until result)
//   isect_done, isect_hit      intersector result strobe and hit qualifier
//   refl_hit_valid, refl_*     reflector request and current path registers
//   reflect_done, new_*        reflector result, sampled on reflect_done
//   pixel_valid, pixel_color,
//   pixel_idx                  finished pixel strobe and payload
//   timeout_err                sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module ray_bounce_ctrl #(
  parameter int unsigned MAX_BOUNCES    = 3,
  parameter int unsigned IDX_W          = 17,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  input  logic [71:0]      cam_origin,
  input  logic [71:0]      cam_dir,
  input  logic [IDX_W-1:0] pixel_idx_in,
  output logic             trace_valid,
  output logic [71:0]      trace_origin,
  output logic [71:0]      trace_dir,
  input  logic             isect_done,
  input  logic             isect_hit,
  output logic             refl_hit_valid,
  output logic [71:0]      refl_ray_dir,
  output logic [71:0]      refl_ray_color,
  output logic [71:0]      refl_income_light,
  input  logic             reflect_done,
  input  logic [71:0]      new_dir,
  input  logic [71:0]      new_origin,
  input  logic [71:0]      new_color,
  input  logic [71:0]      new_income_light,
  output logic             pixel_valid,
  output logic [71:0]      pixel_color,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             timeout_err
);

  localparam logic [23:0] FP24_ONE    = 24'h3F0000;
  localparam logic [71:0] COLOR_WHITE = {3{FP24_ONE}};
  // Watchdog is at least 12 bits wide and always wide enough to hold the limit.
  localparam int unsigned WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 12;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]        BOUNCE_LIMIT = 4'(MAX_BOUNCES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_TRACE   = 3'd2,
    ST_REFLECT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state;
  state_t            w_state_nx;
  logic [71:0]       r_cur_origin;
  logic [71:0]       r_cur_dir;
  logic [71:0]       r_cur_color;
  logic [71:0]       r_cur_light;
  logic [71:0]       r_result;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_bounce;
  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout_err;
  logic [3:0]        w_bounce_inc;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_accept;
  logic              w_hit;
  logic              w_miss;
  logic              w_refl;
  logic              w_refl_last;
  logic              w_timeout;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n      = r_rst_sync[1];
  assign w_bounce_inc = r_bounce + 4'd1;
  assign w_wait_inc   = r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};

  // Next-state and per-cycle event decode.
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_refl      = 1'b0;
    w_refl_last = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = ST_ISSUE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nx = ST_TRACE;
      end
      ST_TRACE: begin
        // A result arriving on the limit cycle wins over the watchdog.
        if (isect_done) begin
          if (isect_hit) begin
            w_hit      = 1'b1;
            w_state_nx = ST_REFLECT;
          end else begin
            w_miss     = 1'b1;
            w_state_nx = ST_DONE;
          end
        end else if (w_wait_inc == WAIT_LIMIT) begin
          w_timeout  = 1'b1;
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_TRACE;
        end
      end
      ST_REFLECT: begin
        if (reflect_done) begin
          w_refl = 1'b1;
          // A fully absorbed ray (all-zero color) cannot contribute further.
          if ((w_bounce_inc == BOUNCE_LIMIT) || (new_color == 72'd0)) begin
            w_refl_last = 1'b1;
            w_state_nx  = ST_DONE;
          end else begin
            w_state_nx  = ST_ISSUE;
          end
        end else if (w_wait_inc == WAIT_LIMIT) begin
          w_timeout  = 1'b1;
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_REFLECT;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Watchdog: counts while staying in TRACE/REFLECT, cleared on any entry.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wait <= {WAIT_W{1'b0}};
    end else if (((r_state == ST_TRACE) || (r_state == ST_REFLECT)) &&
                 (w_state_nx == r_state)) begin
      r_wait <= w_wait_inc;
    end else begin
      r_wait <= {WAIT_W{1'b0}};
    end
  end

  // Current path registers, bounce count and pixel index.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cur_origin <= 72'd0;
      r_cur_dir    <= 72'd0;
      r_cur_color  <= 72'd0;
      r_cur_light  <= 72'd0;
      r_bounce     <= 4'd0;
      r_idx        <= {IDX_W{1'b0}};
    end else if (w_accept) begin
      r_cur_origin <= cam_origin;
      r_cur_dir    <= cam_dir;
      r_cur_color  <= COLOR_WHITE;
      r_cur_light  <= 72'd0;
      r_bounce     <= 4'd0;
      r_idx        <= pixel_idx_in;
    end else if (w_refl) begin
      r_cur_origin <= new_origin;
      r_cur_dir    <= new_dir;
      r_cur_color  <= new_color;
      r_cur_light  <= new_income_light;
      r_bounce     <= w_bounce_inc;
    end
  end

  // Final pixel color and sticky watchdog flag.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_result      <= 72'd0;
      r_timeout_err <= 1'b0;
    end else if (w_miss) begin
      // Miss means black sky: only the light gathered so far remains.
      r_result      <= r_cur_light;
    end else if (w_refl_last) begin
      r_result      <= new_income_light;
    end else if (w_timeout) begin
      r_result      <= 72'd0;
      r_timeout_err <= 1'b1;
    end
  end

  assign start_ready       = (r_state == ST_IDLE);
  assign trace_valid       = (r_state == ST_ISSUE);
  assign trace_origin      = r_cur_origin;
  assign trace_dir         = r_cur_dir;
  assign refl_hit_valid    = w_hit;
  assign refl_ray_dir      = r_cur_dir;
  assign refl_ray_color    = r_cur_color;
  assign refl_income_light = r_cur_light;
  assign pixel_valid       = (r_state == ST_DONE);
  assign pixel_color       = r_result;
  assign pixel_idx         = r_idx;
  assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ray_bounce_ctrl. Main instance (MAX_BOUNCES=3, long watchdog)
// covers miss, full depth, zero-color exit, spurious strobes and reset; a
// second instance with TIMEOUT_CYCLES=15 and a silent intersector covers the
// watchdog. Expected pixels are queued by the stimulus and popped by monitors.
// ---------------------------------------------------------------------------
module tb_ray_bounce_ctrl;
  localparam int IDX_W = 17;
  localparam logic [71:0] WHITE = {3{24'h3F0000}};
  localparam logic [71:0] O1 = 72'h000001_000002_000003, D1 = 72'h3F0000_000000_000000;
  localparam logic [71:0] O2 = 72'h010000_020000_030000, D2 = 72'h000000_3F0000_000000;
  localparam logic [71:0] O3 = 72'h0A0A0A_0B0B0B_0C0C0C, D3 = 72'h000000_000000_BF0000;
  localparam logic [71:0] O4 = 72'h111111_222222_333333, D4 = 72'h3E8000_3E8000_000000;
  localparam logic [71:0] O6 = 72'h444444_555555_666666, D6 = 72'h3F0000_3F0000_3F0000;
  localparam logic [71:0] O7 = 72'h777777_888888_999999, D7 = 72'hBF0000_000000_000000;
  localparam logic [71:0] NO = 72'h123456_789ABC_DEF012, ND = 72'h3E0000_3D0000_3C0000;
  localparam logic [71:0] C1 = 72'h3E8000_3E8000_3E8000, C2 = 72'h3E4000_3E4000_3E4000;
  localparam logic [71:0] C3 = 72'h3E2000_3E2000_3E2000;
  localparam logic [71:0] L1 = 72'h3D0000_3C0000_3B0000, L2 = 72'h3D8000_3C8000_3B8000;
  localparam logic [71:0] L3 = 72'h3E1234_3E5678_3E9ABC, L4 = 72'h3A0001_3A0002_3A0003;
  localparam logic [71:0] L5 = 72'h390F0F_38F0F0_37AAAA, L7 = 72'h3C3C3C_3D3D3D_3E3E3E;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [71:0]      color;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, wd_start, isect_done, isect_hit, reflect_done;
  logic [71:0] cam_origin, cam_dir, new_dir, new_origin, new_color, new_income_light;
  logic [IDX_W-1:0] pixel_idx_in;
  logic start_ready, trace_valid, refl_hit_valid, pixel_valid, timeout_err;
  logic [71:0] trace_origin, trace_dir, refl_ray_dir, refl_ray_color, refl_income_light, pixel_color;
  logic [IDX_W-1:0] pixel_idx;
  logic wd_start_ready, wd_trace_valid, wd_refl_hit_valid, wd_pixel_valid, wd_timeout_err;
  logic [71:0] wd_trace_origin, wd_trace_dir, wd_refl_ray_dir, wd_refl_ray_color;
  logic [71:0] wd_refl_income_light, wd_pixel_color;
  logic [IDX_W-1:0] wd_pixel_idx;

  exp_t sb_q[$];
  exp_t wd_q[$];
  int n_checks = 0, n_fail = 0, n_trace = 0, n_hit = 0, n_pv = 0;
  int t0, h0, p0, k;

  always #5 clk = ~clk;

  ray_bounce_ctrl #(.MAX_BOUNCES(3), .IDX_W(IDX_W), .TIMEOUT_CYCLES(200)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .cam_origin(cam_origin), .cam_dir(cam_dir), .pixel_idx_in(pixel_idx_in),
    .trace_valid(trace_valid), .trace_origin(trace_origin), .trace_dir(trace_dir),
    .isect_done(isect_done), .isect_hit(isect_hit), .refl_hit_valid(refl_hit_valid),
    .refl_ray_dir(refl_ray_dir), .refl_ray_color(refl_ray_color),
    .refl_income_light(refl_income_light), .reflect_done(reflect_done),
    .new_dir(new_dir), .new_origin(new_origin), .new_color(new_color),
    .new_income_light(new_income_light), .pixel_valid(pixel_valid),
    .pixel_color(pixel_color), .pixel_idx(pixel_idx), .timeout_err(timeout_err)
  );

  ray_bounce_ctrl #(.MAX_BOUNCES(3), .IDX_W(IDX_W), .TIMEOUT_CYCLES(15)) u_wd (
    .clk(clk), .rst_n(rst_n), .start(wd_start), .start_ready(wd_start_ready),
    .cam_origin(cam_origin), .cam_dir(cam_dir), .pixel_idx_in(pixel_idx_in),
    .trace_valid(wd_trace_valid), .trace_origin(wd_trace_origin), .trace_dir(wd_trace_dir),
    .isect_done(1'b0), .isect_hit(isect_hit), .refl_hit_valid(wd_refl_hit_valid),
    .refl_ray_dir(wd_refl_ray_dir), .refl_ray_color(wd_refl_ray_color),
    .refl_income_light(wd_refl_income_light), .reflect_done(1'b0),
    .new_dir(new_dir), .new_origin(new_origin), .new_color(new_color),
    .new_income_light(new_income_light), .pixel_valid(wd_pixel_valid),
    .pixel_color(wd_pixel_color), .pixel_idx(wd_pixel_idx), .timeout_err(wd_timeout_err)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_px(input logic [IDX_W-1:0] idx, input logic [71:0] col);
    exp_t e;
    e.idx = idx;
    e.color = col;
    sb_q.push_back(e);
  endtask

  task automatic expect_wd(input logic [IDX_W-1:0] idx, input logic [71:0] col);
    exp_t e;
    e.idx = idx;
    e.color = col;
    wd_q.push_back(e);
  endtask

  // Launch a pixel on the main instance; returns in the trace_valid cycle.
  task automatic launch(input logic [IDX_W-1:0] idx, input logic [71:0] org, input logic [71:0] dir);
    int n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    check1("start_ready_before_launch", start_ready, 1'b1);
    start = 1'b1;
    pixel_idx_in = idx;
    cam_origin = org;
    cam_dir = dir;
    tick();
    start = 1'b0;
    check1("trace_valid_after_accept", trace_valid, 1'b1);
    check("trace_origin_camera", trace_origin, org);
    check("trace_dir_camera", trace_dir, dir);
  endtask

  // Intersector answers wait_n cycles after the trace_valid cycle.
  task automatic isect(input int wait_n, input logic hit);
    for (int i = 0; i < wait_n; i++) tick();
    isect_done = 1'b1;
    isect_hit = hit;
    #1;
    check1("refl_hit_valid_same_cycle", refl_hit_valid, hit);
    tick();
    isect_done = 1'b0;
    isect_hit = 1'b0;
  endtask

  // Reflector answers delay cycles after REFLECT entry.
  task automatic reflect(input int delay, input logic [71:0] p_dir, input logic [71:0] p_org,
                         input logic [71:0] p_col, input logic [71:0] p_light, input logic last);
    for (int i = 1; i < delay; i++) tick();
    reflect_done = 1'b1;
    new_dir = p_dir;
    new_origin = p_org;
    new_color = p_col;
    new_income_light = p_light;
    tick();
    reflect_done = 1'b0;
    check1("pixel_valid_after_reflect", pixel_valid, last);
    check1("trace_valid_after_reflect", trace_valid, !last);
    if (!last) check("trace_origin_bounce", trace_origin, p_org);
  endtask

  // Main monitor: pulse counters and scoreboard pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (trace_valid) n_trace++;
      if (refl_hit_valid) n_hit++;
      if (pixel_valid) begin
        n_pv++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: idx=%0d color=%0h with no expected entry", pixel_idx, pixel_color);
        end else begin
          e = sb_q.pop_front();
          check("pixel_color", pixel_color, e.color);
          check("pixel_idx", 72'(pixel_idx), 72'(e.idx));
        end
      end
    end
  end

  // Watchdog-instance monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wd_pixel_valid) begin
        n_checks++;
        if (wd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_wd_pixel: idx=%0d with no expected entry", wd_pixel_idx);
        end else begin
          e = wd_q.pop_front();
          check("wd_pixel_color", wd_pixel_color, e.color);
          check("wd_pixel_idx", 72'(wd_pixel_idx), 72'(e.idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wd_start = 1'b0; isect_done = 1'b0; isect_hit = 1'b0;
    reflect_done = 1'b0; cam_origin = 72'd0; cam_dir = 72'd0; pixel_idx_in = '0;
    new_dir = 72'd0; new_origin = 72'd0; new_color = 72'd0; new_income_light = 72'd0;
    repeat (3) tick();
    check1("reset_start_ready", start_ready, 1'b1);
    check1("reset_trace_valid", trace_valid, 1'b0);
    check1("reset_pixel_valid", pixel_valid, 1'b0);
    check1("reset_timeout_err", timeout_err, 1'b0);
    check1("reset_wd_timeout_err", wd_timeout_err, 1'b0);
    check("reset_pixel_color", pixel_color, 72'd0);
    check("reset_trace_origin", trace_origin, 72'd0);
    check("reset_refl_ray_color", refl_ray_color, 72'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Immediate miss
    t0 = n_trace; h0 = n_hit;
    expect_px(17'd5, 72'd0);
    launch(17'd5, O1, D1);
    isect(3, 1'b0);
    check1("miss_pixel_valid_next_cycle", pixel_valid, 1'b1);
    check1("start_ready_low_in_done", start_ready, 1'b0);
    tick();
    check1("start_ready_after_pixel", start_ready, 1'b1);
    check("miss_trace_count", 72'(n_trace - t0), 72'd1);
    check("miss_hit_count", 72'(n_hit - h0), 72'd0);

    // Full depth: three bounces, result is the third income light
    t0 = n_trace; h0 = n_hit;
    expect_px(17'd7, L3);
    launch(17'd7, O2, D2);
    isect(2, 1'b1);
    check("first_bounce_color_white", refl_ray_color, WHITE);
    check("first_bounce_light_zero", refl_income_light, 72'd0);
    check("first_bounce_dir", refl_ray_dir, D2);
    reflect(20, ND, NO, C1, L1, 1'b0);
    isect(2, 1'b1);
    check("second_bounce_color", refl_ray_color, C1);
    check("second_bounce_light", refl_income_light, L1);
    reflect(20, D3, O3, C2, L2, 1'b0);
    isect(2, 1'b1);
    reflect(20, D4, O4, C3, L3, 1'b1);
    tick();
    check("full_trace_count", 72'(n_trace - t0), 72'd3);
    check("full_hit_count", 72'(n_hit - h0), 72'd3);

    // Zero-color early exit
    t0 = n_trace;
    expect_px(17'd9, L4);
    launch(17'd9, O3, D3);
    isect(1, 1'b1);
    reflect(5, ND, NO, 72'd0, L4, 1'b1);
    tick();
    check("zero_color_trace_count", 72'(n_trace - t0), 72'd1);

    // Spurious strobes
    t0 = n_trace; h0 = n_hit;
    expect_px(17'd11, L5);
    launch(17'd11, O4, D4);
    tick();
    reflect_done = 1'b1; new_color = 72'd0; new_income_light = L1; new_origin = NO;
    start = 1'b1; pixel_idx_in = 17'd99; cam_origin = O7;
    tick();
    reflect_done = 1'b0; start = 1'b0;
    check1("spurious_start_ready", start_ready, 1'b0);
    check1("spurious_no_pixel", pixel_valid, 1'b0);
    check1("spurious_no_retrace", trace_valid, 1'b0);
    check("spurious_origin_held", trace_origin, O4);
    check("spurious_idx_held", 72'(pixel_idx), 72'd11);
    isect(1, 1'b1);
    isect_done = 1'b1; isect_hit = 1'b1; start = 1'b1;
    #1;
    check1("spurious_isect_in_reflect", refl_hit_valid, 1'b0);
    tick();
    isect_done = 1'b0; isect_hit = 1'b0; start = 1'b0;
    check1("spurious_no_issue_in_reflect", trace_valid, 1'b0);
    check("spurious_idx_held2", 72'(pixel_idx), 72'd11);
    reflect(3, ND, NO, 72'd0, L5, 1'b1);
    tick();
    check("spurious_trace_count", 72'(n_trace - t0), 72'd1);
    check("spurious_hit_count", 72'(n_hit - h0), 72'd1);

    // Watchdog: silent intersector, TIMEOUT_CYCLES=15
    expect_wd(17'd21, 72'd0);
    wd_start = 1'b1; pixel_idx_in = 17'd21;
    tick();
    wd_start = 1'b0;
    check1("wd_trace_valid", wd_trace_valid, 1'b1);
    k = 0;
    while (!wd_pixel_valid && k < 40) begin tick(); k++; end
    check("wd_latency_from_trace", 72'(k), 72'd16);
    check1("wd_timeout_err_set", wd_timeout_err, 1'b1);
    tick();
    check1("wd_start_ready_after", wd_start_ready, 1'b1);
    expect_wd(17'd22, 72'd0);
    wd_start = 1'b1; pixel_idx_in = 17'd22;
    tick();
    wd_start = 1'b0;
    repeat (5) tick();
    check1("wd_timeout_err_sticky", wd_timeout_err, 1'b1);
    k = 0;
    while (!wd_pixel_valid && k < 40) begin tick(); k++; end
    check("wd_latency_second", 72'(k), 72'd11);
    tick();
    check1("main_timeout_err_clear", timeout_err, 1'b0);

    // Reset mid-REFLECT, then a normal pixel ending in a miss after one bounce
    p0 = n_pv;
    launch(17'd13, O6, D6);
    isect(1, 1'b1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_refl_ray_color", refl_ray_color, 72'd0);
    check("rst_refl_ray_dir", refl_ray_dir, 72'd0);
    check("rst_trace_origin", trace_origin, 72'd0);
    check1("rst_start_ready", start_ready, 1'b1);
    check1("rst_pixel_valid", pixel_valid, 1'b0);
    check1("rst_wd_timeout_err", wd_timeout_err, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check1("rst_start_ready_after", start_ready, 1'b1);
    check("rst_no_pixel", 72'(n_pv - p0), 72'd0);
    expect_px(17'd14, L7);
    launch(17'd14, O7, D7);
    isect(2, 1'b1);
    reflect(4, ND, NO, C2, L7, 1'b0);
    isect(3, 1'b0);
    check1("post_reset_pixel_valid", pixel_valid, 1'b1);
    repeat (3) tick();

    check("sb_queue_drained", 72'(sb_q.size()), 72'd0);
    check("wd_queue_drained", 72'(wd_q.size()), 72'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
